dout_display: RTL
=================

DOUT_DISPLAY -- requirements
Module: dout_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 50000, clk cycles each digit is driven before the scan advances (minimum 2).
REQ-002 clk  in  1  system clock; all state updates on posedge clk.
REQ-003 resetn  in  1  reset; asynchronous, active-low.
REQ-004 enable  in  1  capture gate; high permits new conversions.
REQ-005 dout_value  in  8  binary value from the CPU special output register (DOUT).
REQ-006 signed_mode  in  1  1 = dout_value is two's complement; 0 = unsigned.
REQ-007 seg  out  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-008 an  out  4  digit anode select, one-hot active-low; an[0] = ones digit, an[3] = sign digit.
REQ-009 busy  out  1  high while a conversion is in progress.

Function
REQ-010 FSM states SHALL be IDLE, CONVERT and LATCH; reset state is IDLE.
REQ-011 IDLE: when enable=1 and {dout_value, signed_mode} differs from the stored last pair, the block SHALL capture both, update the last pair, and enter CONVERT on the next edge.
REQ-012 Magnitude: if signed_mode=1 and dout_value[7]=1, then neg=1 and mag = two's-complement negation as a 9-bit value (0x80 -> 128); otherwise neg=0 and mag = dout_value.
REQ-013 CONVERT SHALL run exactly 8 cycles of shift-and-add-3 on a 20-bit register (12 BCD bits + 8 binary bits): add 3 to each BCD nibble >= 5, then shift left by 1.
REQ-014 After the 8th CONVERT cycle the FSM SHALL enter LATCH. LATCH (1 cycle) SHALL load the hundreds, tens, ones and neg display registers, then return to IDLE.
REQ-015 Latency from the capture edge to updated display registers SHALL be 10 cycles (1 capture + 8 convert + 1 latch).
REQ-016 busy SHALL be 1 in CONVERT and LATCH and 0 in IDLE.
REQ-017 Input changes during CONVERT or LATCH SHALL be ignored; the comparison in IDLE SHALL detect the change and start a new conversion.
REQ-018 enable=0 SHALL block new captures only; a conversion in progress SHALL complete, and scanning SHALL continue.
REQ-019 Blanking: hundreds digit blank if 0; tens digit blank if hundreds=0 and tens=0; ones digit always shown.
REQ-020 Sign digit SHALL show minus (seg=7'b0111111) when neg=1, and blank (7'b1111111) otherwise.
REQ-021 Digit encodings 0-9 SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-022 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0. On each wrap the digit index SHALL advance 0->1->2->3->0.
REQ-023 an and seg SHALL be registered and update together, so no cycle drives a mismatched digit/segment pair.

Reset
REQ-024 Reset SHALL set: state=IDLE, last pair = {0x00, 0}, display regs = 0 with neg=0, refresh counter and digit index = 0, an=4'b1110, seg=7'b1000000, busy=0.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion immediately and leave no partial result in the display registers.
REQ-026 Because the reset last pair matches {0x00, 0}, an input of 0 unsigned after reset SHALL NOT trigger a conversion.

Verification
REQ-027 Unsigned: dout_value=0xFF, signed_mode=0 -> busy high 9 cycles; digits 2,5,5 after 10 cycles; sign blank.
REQ-028 Signed: dout_value=0x80, signed_mode=1 -> display shows -,1,2,8. Then dout_value=0xFF -> display shows -,blank,blank,1.
REQ-029 Mid-conversion change: 0x05 followed by 0x2A three cycles later -> display shows 5 at cycle 10, then a second conversion with 42 displayed no later than cycle 21.
REQ-030 Scan with REFRESH_DIV=4: an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; seg matches the selected digit every cycle.
REQ-031 Reset pulse during CONVERT of 0x63 -> outputs return to reset values immediately; no 99 appears afterwards unless the input is held and re-detected.
REQ-032 enable=0 with dout_value changed to 0x10 -> no busy and no display change; raising enable starts the conversion on the next edge.

Source files
------------

// File: rtl/dout_display.sv
// Drives a 4-digit seven-segment display with the decimal value of the CPU DOUT register.
// The value is converted with a serial double-dabble, then shown as sign, hundreds, tens and ones.
module dout_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] dout_value,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

    state_t           state, state_next;
    logic [7:0]       last_value;
    logic             last_signed;
    logic [19:0]      shift_reg;
    logic [2:0]       bit_cnt;
    logic             neg_work;
    logic [3:0]       disp_hund, disp_tens, disp_ones;
    logic             disp_neg;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic             start;
    logic             in_neg;
    logic [7:0]       in_mag;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;

    // One double-dabble step: correct every BCD nibble that would overflow, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5)
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign start  = (state == IDLE) && enable &&
                    ({dout_value, signed_mode} != {last_value, last_signed});
    assign in_neg = signed_mode & dout_value[7];
    // 8-bit negation is enough: -128 wraps to 0x80, which read unsigned is 128.
    assign in_mag = in_neg ? (~dout_value + 8'd1) : dout_value;
    assign busy   = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (bit_cnt == 3'd7) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_value  <= 8'h00;
            last_signed <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            neg_work    <= 1'b0;
            disp_hund   <= '0;
            disp_tens   <= '0;
            disp_ones   <= '0;
            disp_neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    last_value  <= dout_value;
                    last_signed <= signed_mode;
                    shift_reg   <= {12'd0, in_mag};
                    neg_work    <= in_neg;
                    bit_cnt     <= '0;
                end
                CONVERT: begin
                    shift_reg <= dd_step(shift_reg);
                    bit_cnt   <= bit_cnt + 3'd1;
                end
                LATCH: begin
                    disp_hund <= shift_reg[19:16];
                    disp_tens <= shift_reg[15:12];
                    disp_ones <= shift_reg[11:8];
                    disp_neg  <= neg_work;
                end
                default: ;
            endcase
        end
    end

    // Digit 0 is the ones place (an[0]); digit 3 is the sign.
    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = ~(4'b0001 << digit_idx);
        case (digit_idx)
            2'd0: seg_next = seg_enc(disp_ones);
            2'd1: seg_next = (disp_hund == 4'd0 && disp_tens == 4'd0) ? SEG_BLANK : seg_enc(disp_tens);
            2'd2: seg_next = (disp_hund == 4'd0) ? SEG_BLANK : seg_enc(disp_hund);
            2'd3: seg_next = disp_neg ? SEG_MINUS : SEG_BLANK;
            default: seg_next = SEG_BLANK;
        endcase
    end

    // an and seg come from the same register stage so a digit never shows another's pattern.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            an          <= 4'b1110;
            seg         <= 7'b1000000;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
